// File: rtl/fir_pkg.sv
// Shared types and address helper for the multi-channel FIR delay line.
package fir_pkg;

    localparam int unsigned DEF_FILTER_IN_BITS     = 16;
    localparam int unsigned DEF_NUMBER_OF_TAPS     = 64;
    localparam int unsigned DEF_NUMBER_OF_CHANNELS = 2;
    localparam int unsigned DEF_TAP_BITS           = $clog2(DEF_NUMBER_OF_TAPS);
    localparam int unsigned DEF_CH_BITS            =
        (DEF_NUMBER_OF_CHANNELS > 1) ? $clog2(DEF_NUMBER_OF_CHANNELS) : 1;

    typedef logic signed [DEF_FILTER_IN_BITS-1:0] sample_t;
    typedef logic [DEF_TAP_BITS-1:0]              tap_idx_t;
    typedef logic [DEF_CH_BITS-1:0]               chan_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // (base - k) mod n without a divider, valid for any n > k
    function automatic int unsigned tap_addr(input int unsigned base,
                                             input int unsigned k,
                                             input int unsigned n);
        return (base >= k) ? (base - k) : (base + n - k);
    endfunction

endpackage

// File: rtl/mc_delay_pipeline_tap_sweep_counter.sv
// Tap index counter for one history sweep: restarts at 0, saturates at limit.
module tap_sweep_counter #(
    parameter int unsigned IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_enable,
    input  logic                start,
    input  logic [IDX_BITS-1:0] limit,
    output logic [IDX_BITS-1:0] count,
    output logic                last_c,
    output logic                first_c
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clk_enable) begin
            if (start) begin
                count <= '0;
            end else if (count != limit) begin
                count <= count + IDX_BITS'(1);
            end
        end
    end

    assign last_c  = (count == limit);
    assign first_c = (count == '0);

endmodule

// File: rtl/mc_delay_pipeline.sv
// Multi-channel circular-buffer delay line feeding a serial FIR MAC, newest tap first.
// Optional SYMMETRIC_FOLD_EN: half-length sweep with a mirrored tap output for folded FIRs.
module mc_delay_pipeline
    import fir_pkg::*;
#(
    parameter int unsigned FILTER_IN_BITS     = 16,
    parameter int unsigned NUMBER_OF_TAPS     = 64,
    parameter int unsigned NUMBER_OF_CHANNELS = 2,
    localparam int unsigned CH_BITS  = (NUMBER_OF_CHANNELS > 1) ? $clog2(NUMBER_OF_CHANNELS) : 1,
    localparam int unsigned IDX_BITS = $clog2(NUMBER_OF_TAPS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clk_enable,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CH_BITS-1:0]               in_channel,
    input  logic signed [FILTER_IN_BITS-1:0] filter_in,
    output logic signed [FILTER_IN_BITS-1:0] delay_filter_in,
`ifdef SYMMETRIC_FOLD_EN
    output logic signed [FILTER_IN_BITS-1:0] delay_filter_in_mirror,
`endif
    output logic                             tap_valid,
    output logic [IDX_BITS-1:0]              current_count,
    output logic                             phase_min,
    output logic                             tap_last,
    output logic [CH_BITS-1:0]               tap_channel,
    output logic                             chan_err
);

`ifdef SYMMETRIC_FOLD_EN
    localparam int unsigned SWEEP_LEN = NUMBER_OF_TAPS / 2;
`else
    localparam int unsigned SWEEP_LEN = NUMBER_OF_TAPS;
`endif
    localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(NUMBER_OF_TAPS - 1);
    localparam logic [IDX_BITS-1:0] SWEEP_LIM = IDX_BITS'(SWEEP_LEN - 1);

    logic signed [FILTER_IN_BITS-1:0] hist [NUMBER_OF_CHANNELS][NUMBER_OF_TAPS];
    logic [IDX_BITS-1:0]              wr_ptr [NUMBER_OF_CHANNELS];
    logic [IDX_BITS-1:0]              base;
    logic [CH_BITS-1:0]               sweep_ch;
    state_t                           state;

    logic                chan_ok;
    logic                accept;
    logic                start;
    logic [IDX_BITS-1:0] count;
    logic                last_c;
    logic                first_c;
    logic [IDX_BITS-1:0] rd_addr;
`ifdef SYMMETRIC_FOLD_EN
    logic [IDX_BITS-1:0] rd_addr_mirror;
`endif

    assign in_ready = (state == IDLE);
    assign chan_ok  = (32'(in_channel) < NUMBER_OF_CHANNELS);
    assign accept   = in_valid && in_ready && clk_enable;
    assign start    = accept && chan_ok;

    // Circular read addresses relative to the slot written at accept time
    assign rd_addr = IDX_BITS'(tap_addr(32'(base), 32'(count), NUMBER_OF_TAPS));
`ifdef SYMMETRIC_FOLD_EN
    assign rd_addr_mirror = IDX_BITS'(tap_addr(32'(base), NUMBER_OF_TAPS - 1 - 32'(count),
                                               NUMBER_OF_TAPS));
`endif

    tap_sweep_counter #(
        .IDX_BITS (IDX_BITS)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .start      (start),
        .limit      (SWEEP_LIM),
        .count      (count),
        .last_c     (last_c),
        .first_c    (first_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            base            <= '0;
            sweep_ch        <= '0;
            delay_filter_in <= '0;
`ifdef SYMMETRIC_FOLD_EN
            delay_filter_in_mirror <= '0;
`endif
            tap_valid       <= 1'b0;
            current_count   <= '0;
            phase_min       <= 1'b0;
            tap_last        <= 1'b0;
            tap_channel     <= '0;
            chan_err        <= 1'b0;
            for (int c = 0; c < NUMBER_OF_CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                for (int t = 0; t < NUMBER_OF_TAPS; t++) begin
                    hist[c][t] <= '0;
                end
            end
        end else if (clk_enable) begin
            chan_err <= 1'b0;
            case (state)
                IDLE: begin
                    tap_valid <= 1'b0;
                    tap_last  <= 1'b0;
                    phase_min <= 1'b0;
                    if (in_valid) begin
                        if (chan_ok) begin
                            hist[in_channel][wr_ptr[in_channel]] <= filter_in;
                            wr_ptr[in_channel] <= (wr_ptr[in_channel] == LAST_IDX) ?
                                                  '0 : wr_ptr[in_channel] + IDX_BITS'(1);
                            base     <= wr_ptr[in_channel];
                            sweep_ch <= in_channel;
                            state    <= SWEEP;
                        end else begin
                            chan_err <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    delay_filter_in <= hist[sweep_ch][rd_addr];
`ifdef SYMMETRIC_FOLD_EN
                    delay_filter_in_mirror <= hist[sweep_ch][rd_addr_mirror];
`endif
                    current_count <= count;
                    tap_valid     <= 1'b1;
                    tap_last      <= last_c;
                    phase_min     <= first_c;
                    tap_channel   <= sweep_ch;
                    if (last_c) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_delay_pipeline.sv
// Scoreboard bench for mc_delay_pipeline (N=8, two channels, plus a one-channel instance).
module tb_mc_delay_pipeline;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = 8;
    localparam int unsigned NC = 2;
`ifdef SYMMETRIC_FOLD_EN
    localparam int unsigned SWEEP_LEN = N / 2;
`else
    localparam int unsigned SWEEP_LEN = N;
`endif

    typedef struct {
        logic [0:0]   ch;
        int unsigned  k;
        logic [W-1:0] data;
        logic [W-1:0] mirror;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_enable;
    logic         in_valid;
    logic         in_valid1;
    logic [0:0]   in_channel;
    logic [W-1:0] filter_in;

    logic         in_ready, tap_valid, phase_min, tap_last, chan_err;
    logic [W-1:0] delay_filter_in, delay_filter_in_mirror;
    logic [2:0]   current_count;
    logic [0:0]   tap_channel;

    logic         in_ready1, tap_valid1, phase_min1, tap_last1, chan_err1;
    logic [W-1:0] delay_filter_in1, delay_filter_in_mirror1;
    logic [2:0]   current_count1;
    logic [0:0]   tap_channel1;

    int checks   = 0;
    int failures = 0;

    exp_t         sb[$];
    exp_t         e;
    logic [W-1:0] model0[$];
    logic [W-1:0] model1[$];
    logic         en_q = 1'b0;

    always #5 clk = ~clk;

    mc_delay_pipeline #(.FILTER_IN_BITS(W), .NUMBER_OF_TAPS(N), .NUMBER_OF_CHANNELS(NC)) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_channel(in_channel), .filter_in(filter_in), .delay_filter_in(delay_filter_in),
`ifdef SYMMETRIC_FOLD_EN
        .delay_filter_in_mirror(delay_filter_in_mirror),
`endif
        .tap_valid(tap_valid), .current_count(current_count), .phase_min(phase_min),
        .tap_last(tap_last), .tap_channel(tap_channel), .chan_err(chan_err)
    );

    mc_delay_pipeline #(.FILTER_IN_BITS(W), .NUMBER_OF_TAPS(N), .NUMBER_OF_CHANNELS(1)) dut1 (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_channel(in_channel), .filter_in(filter_in), .delay_filter_in(delay_filter_in1),
`ifdef SYMMETRIC_FOLD_EN
        .delay_filter_in_mirror(delay_filter_in_mirror1),
`endif
        .tap_valid(tap_valid1), .current_count(current_count1), .phase_min(phase_min1),
        .tap_last(tap_last1), .tap_channel(tap_channel1), .chan_err(chan_err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // k-th most recent sample of a channel, zero before the history fills
    function automatic logic [W-1:0] model_tap(input int ch, input int k);
        int sz;
        sz = (ch == 0) ? model0.size() : model1.size();
        if (k >= sz) return '0;
        return (ch == 0) ? model0[sz-1-k] : model1[sz-1-k];
    endfunction

    always @(posedge clk) en_q <= clk_enable;

    // Each enabled edge leaving tap_valid high is one new tap
    always @(negedge clk) begin
        if (en_q && tap_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_tap", 32'(tap_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check("tap_data", 32'(delay_filter_in), 32'(e.data));
                check("tap_index", 32'(current_count), e.k);
                check("tap_channel", 32'(tap_channel), 32'(e.ch));
                check("phase_min", 32'(phase_min), 32'(e.k == 0));
                check("tap_last", 32'(tap_last), 32'(e.k == SWEEP_LEN - 1));
`ifdef SYMMETRIC_FOLD_EN
                check("tap_mirror", 32'(delay_filter_in_mirror), 32'(e.mirror));
`endif
            end
        end
    end

    task automatic clear_model();
        sb.delete();
        model0.delete();
        model1.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic push(input logic [0:0] ch, input logic [W-1:0] val);
        int waited = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("push_ready", 32'(in_ready), 32'(1));
        if (ch == 1'b0) model0.push_back(val);
        else            model1.push_back(val);
        for (int k = 0; k < SWEEP_LEN; k++) begin
            sb.push_back('{ch, k, model_tap(int'(ch), k), model_tap(int'(ch), N - 1 - k)});
        end
        in_valid   = 1'b1;
        in_channel = ch;
        filter_in  = val;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_after_accept", 32'(in_ready), 32'(0));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'(0));
    endtask

    task automatic wait_tap(input int unsigned k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tap_valid && current_count == 3'(k)) && n < 50);
        check("wait_tap_reached", 32'(current_count), k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        clk_enable = 1'b1;
        in_valid   = 1'b0;
        in_valid1  = 1'b0;
        in_channel = '0;
        filter_in  = '0;
        do_reset();

        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_tap_valid", 32'(tap_valid), 32'(0));
        check("rst_data", 32'(delay_filter_in), 32'(0));
        check("rst_count", 32'(current_count), 32'(0));
        check("rst_flags", 32'({phase_min, tap_last, chan_err}), 32'(0));
        check("rst_tap_channel", 32'(tap_channel), 32'(0));

        // single sample into empty history, then pointer wrap
        push(1'b0, 16'h0001);
        drain();
        for (int v = 2; v <= 9; v++) begin
            push(1'b0, 16'(v));
            drain();
        end

        // interleaved channels stay independent
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 16'h1000);
            drain();
            push(1'b1, 16'h2000);
            drain();
        end

        // clock-enable freeze at k=3
        push(1'b0, 16'h0A5A);
        wait_tap(3);
        clk_enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("freeze_count", 32'(current_count), 32'(3));
            check("freeze_data", 32'(delay_filter_in), 32'(model_tap(0, 3)));
            check("freeze_valid", 32'(tap_valid), 32'(1));
        end
        clk_enable = 1'b1;
        drain();

        // reset mid-sweep
        push(1'b0, 16'h1111);
        wait_tap(5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tap_valid", 32'(tap_valid), 32'(0));
        check("rst_mid_in_ready", 32'(in_ready), 32'(1));
        clear_model();
        rst = 1'b0;
        push(1'b0, 16'h2222);
        drain();

        // out-of-range channel on the single-channel instance
        in_channel = 1'b1;
        filter_in  = 16'h0BAD;
        in_valid1  = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check("chan_err_pulse", 32'(chan_err1), 32'(1));
        check("drop_in_ready", 32'(in_ready1), 32'(1));
        check("drop_no_tap", 32'(tap_valid1), 32'(0));
        @(posedge clk);
        #1;
        check("chan_err_clear", 32'(chan_err1), 32'(0));
        check("drop_no_tap_2", 32'(tap_valid1), 32'(0));
        in_channel = 1'b0;
        filter_in  = 16'h0777;
        in_valid1  = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check("ch1inst_busy", 32'(in_ready1), 32'(0));
        @(posedge clk);
        #1;
        check("ch1inst_tap0", 32'(delay_filter_in1), 32'(16'h0777));
        check("ch1inst_tap0_valid", 32'(tap_valid1), 32'(1));
        @(posedge clk);
        #1;
        check("ch1inst_tap1_untouched", 32'(delay_filter_in1), 32'(0));
        repeat (SWEEP_LEN + 2) @(posedge clk);
        #1;
        check("ch1inst_idle", 32'(in_ready1), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
